// File: rtl/riscv_pkg.sv
// Shared RV32I core types and constants used by the fetch stage.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
        return addr & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Register-based FIFO with registered head, synchronous flush and async active-low reset.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] popData,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic             doPush;
    logic             doPop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign popData = mem[rdPtr];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign doPop  = pop && !flush && !empty;
    assign doPush = push && !flush && (!full || doPop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            case ({doPush, doPop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: PC generation, credit-limited imem requests,
// in-order instruction buffer feeding decode, and redirect flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    output logic        ValidD,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D
);

    import riscv_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] pcF;
    logic [XLEN-1:0] lastPc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   dropCnt;

    logic [XLEN-1:0] tagHead;
    logic            tagFull;
    logic            tagEmpty;
    logic [CW-1:0]   tagCount;

    fetch_entry_t    bufIn;
    fetch_entry_t    bufHead;
    logic [$bits(fetch_entry_t)-1:0] bufHeadRaw;
    logic            bufFull;
    logic            bufEmpty;
    logic [CW-1:0]   bufCount;

    logic            reqFire;
    logic            respAny;
    logic            respKeep;
    logic            headPop;
    logic [CW:0]     creditSum;

    assign ValidD  = !bufEmpty;
    assign bufHead = fetch_entry_t'(bufHeadRaw);
    assign headPop = ValidD && !StallD && !PCSrcE;

    // Credits: outstanding requests plus buffered entries, less the entry leaving now.
    assign creditSum = {1'b0, inflight} + {1'b0, bufCount} - (CW + 1)'(headPop);

    assign imem_req_valid = rst_n && !PCSrcE && !tagFull && (creditSum < DEPTH_LIM);
    assign imem_req_addr  = pcF;
    assign reqFire        = imem_req_valid && imem_req_ready;

    assign respAny  = imem_resp_valid && !tagEmpty;
    assign respKeep = respAny && !PCSrcE && (dropCnt == '0);

    assign bufIn.instr = imem_resp_data;
    assign bufIn.pc    = tagHead;

    assign InstrD   = ValidD ? bufHead.instr : NOP_INSTR;
    assign PCD      = ValidD ? bufHead.pc : lastPc;
    assign PCPlus4D = PCD + 32'd4;

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (DEPTH)
    ) u_tagFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (1'b0),
        .push     (reqFire),
        .pushData (pcF),
        .pop      (respAny),
        .popData  (tagHead),
        .full     (tagFull),
        .empty    (tagEmpty),
        .count    (tagCount)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_instrBuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (PCSrcE),
        .push     (respKeep),
        .pushData (bufIn),
        .pop      (headPop),
        .popData  (bufHeadRaw),
        .full     (bufFull),
        .empty    (bufEmpty),
        .count    (bufCount)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcF      <= RESET_PC;
            lastPc   <= RESET_PC;
            inflight <= '0;
            dropCnt  <= '0;
        end else begin
            if (PCSrcE)
                pcF <= alignWord(PCTargetE);
            else if (reqFire)
                pcF <= pcF + 32'd4;

            inflight <= inflight + CW'(reqFire) - CW'(respAny);

            // Everything still outstanding after a redirect belongs to the wrong path.
            if (PCSrcE)
                dropCnt <= inflight - CW'(respAny);
            else if (respAny && (dropCnt != '0))
                dropCnt <= dropCnt - CW'(1);

            if (ValidD)
                lastPc <= bufHead.pc;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n) tagCount == inflight);
    assert property (@(posedge clk) disable iff (!rst_n) !(bufFull && respKeep && !headPop));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency instruction memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallD;
    logic        ValidD;
    logic [31:0] InstrD;
    logic [31:0] PCD;
    logic [31:0] PCPlus4D;

    int nChecks = 0;
    int nFails  = 0;

    int          lat = 1;
    int          cyc = 0;
    logic [31:0] qAddr [$];
    int          qDue  [$];
    logic        memFire;
    logic        memTook;
    logic [31:0] memAddr;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .PCSrcE          (PCSrcE),
        .PCTargetE       (PCTargetE),
        .StallD          (StallD),
        .ValidD          (ValidD),
        .InstrD          (InstrD),
        .PCD             (PCD),
        .PCPlus4D        (PCPlus4D)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic doReset(input int newLat);
        rst_n          = 1'b0;
        lat            = newLat;
        StallD         = 1'b0;
        PCSrcE         = 1'b0;
        PCTargetE      = 32'h0;
        imem_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // Memory: samples the handshake late in the cycle, answers in order after lat edges.
    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(negedge clk);
            #3;
            memFire = imem_req_valid && imem_req_ready;
            memTook = imem_resp_valid;
            memAddr = imem_req_addr;
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                qAddr.delete();
                qDue.delete();
            end else begin
                if (memTook && qAddr.size() > 0) begin
                    void'(qAddr.pop_front());
                    void'(qDue.pop_front());
                end
                if (memFire) begin
                    qAddr.push_back(memAddr);
                    qDue.push_back(cyc + lat);
                end
            end
            #1;
            if (rst_n && qAddr.size() > 0 && qDue[0] <= cyc + 1) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = memWord(qAddr[0]);
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = 32'h0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", nChecks);
        $fatal(1);
    end

    initial begin
        StallD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0; imem_req_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkVal("rst_valid", ValidD, 0);
        checkVal("rst_instr", InstrD, NOP);
        checkVal("rst_pcd", PCD, 32'h0);
        checkVal("rst_pcp4", PCPlus4D, 32'h4);
        checkVal("rst_req", imem_req_valid, 0);

        // Streaming with 1-cycle memory
        rst_n = 1'b1;
        #1;
        checkVal("s_req0_v", imem_req_valid, 1);
        checkVal("s_req0_a", imem_req_addr, 32'h0);
        step();
        checkVal("s_req4_a", imem_req_addr, 32'h4);
        checkVal("s_v_c1", ValidD, 0);
        step();
        checkVal("s_v_c2", ValidD, 1);
        checkVal("s_pcd0", PCD, 32'h0);
        checkVal("s_instr0", InstrD, memWord(32'h0));
        checkVal("s_req8_a", imem_req_addr, 32'h8);
        step();
        checkVal("s_pcd4", PCD, 32'h4);
        checkVal("s_v_c3", ValidD, 1);
        checkVal("s_reqc_a", imem_req_addr, 32'hC);
        step();
        checkVal("s_pcd8", PCD, 32'h8);
        checkVal("s_instr8", InstrD, memWord(32'h8));

        // Decode stall fills the buffer and blocks requests
        StallD = 1'b1;
        #1;
        checkVal("st_req_blk", imem_req_valid, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            checkVal("st_pcd", PCD, 32'h8);
            checkVal("st_instr", InstrD, memWord(32'h8));
            checkVal("st_req_full", imem_req_valid, 0);
        end
        StallD = 1'b0;
        #1;
        checkVal("st_rel_req", imem_req_valid, 1);
        checkVal("st_rel_addr", imem_req_addr, 32'h10);
        step();
        checkVal("st_pcdc", PCD, 32'hC);
        step();
        checkVal("st_pcd10", PCD, 32'h10);

        // Memory not ready: address holds
        imem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkVal("nr_addr", imem_req_addr, 32'h18);
            step();
        end
        checkVal("nr_valid", ValidD, 0);
        checkVal("nr_pcd_last", PCD, 32'h14);
        checkVal("nr_instr_nop", InstrD, NOP);
        checkVal("nr_pcp4", PCPlus4D, 32'h18);
        imem_req_ready = 1'b1;
        step();
        checkVal("nr_v1", ValidD, 0);
        checkVal("nr_addr1c", imem_req_addr, 32'h1C);
        step();
        checkVal("nr_v2", ValidD, 1);
        checkVal("nr_pcd18", PCD, 32'h18);

        // Redirect flushes a buffered, stalled entry
        StallD = 1'b1;
        step();
        checkVal("fl_pcd", PCD, 32'h18);
        PCSrcE = 1'b1; PCTargetE = 32'h200;
        #1;
        checkVal("fl_req_blk", imem_req_valid, 0);
        step();
        PCSrcE = 1'b0; StallD = 1'b0;
        #1;
        checkVal("fl_valid", ValidD, 0);
        checkVal("fl_instr", InstrD, NOP);
        checkVal("fl_pcd_last", PCD, 32'h18);
        checkVal("fl_addr", imem_req_addr, 32'h200);
        checkVal("fl_req", imem_req_valid, 1);
        step();
        step();
        checkVal("fl_v_tgt", ValidD, 1);
        checkVal("fl_pcd_tgt", PCD, 32'h200);

        // 3-cycle memory, redirect with two requests in flight
        doReset(3);
        step();
        checkVal("rd_addr4", imem_req_addr, 32'h4);
        step();
        checkVal("rd_credit", imem_req_valid, 0);
        PCSrcE = 1'b1; PCTargetE = 32'h103;
        step();
        PCSrcE = 1'b0;
        #1;
        checkVal("rd_v0", ValidD, 0);
        checkVal("rd_addr", imem_req_addr, 32'h100);
        step();
        checkVal("rd_v1", ValidD, 0);
        checkVal("rd_req", imem_req_valid, 1);
        checkVal("rd_addr2", imem_req_addr, 32'h100);
        for (int i = 0; i < 3; i++) begin
            step();
            checkVal("rd_v_drop", ValidD, 0);
        end
        step();
        checkVal("rd_v_tgt", ValidD, 1);
        checkVal("rd_pcd", PCD, 32'h100);
        checkVal("rd_instr", InstrD, memWord(32'h100));
        checkVal("rd_pcp4", PCPlus4D, 32'h104);
        step();
        checkVal("rd_pcd104", PCD, 32'h104);

        // Asynchronous reset mid-stream
        #1 rst_n = 1'b0;
        #1;
        checkVal("ar_valid", ValidD, 0);
        checkVal("ar_pcd", PCD, 32'h0);
        checkVal("ar_instr", InstrD, NOP);
        checkVal("ar_pcp4", PCPlus4D, 32'h4);
        checkVal("ar_req", imem_req_valid, 0);
        lat = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("ar_restart_a", imem_req_addr, 32'h0);
        checkVal("ar_restart_v", imem_req_valid, 1);
        step();
        step();
        checkVal("ar_v", ValidD, 1);
        checkVal("ar_pcd0", PCD, 32'h0);

        // Redirect coincident with a response
        doReset(1);
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h40;
        #1;
        checkVal("co_req_blk", imem_req_valid, 0);
        step();
        PCSrcE = 1'b0;
        #1;
        checkVal("co_valid", ValidD, 0);
        checkVal("co_addr", imem_req_addr, 32'h40);
        step();
        checkVal("co_valid2", ValidD, 0);
        step();
        checkVal("co_v_tgt", ValidD, 1);
        checkVal("co_pcd", PCD, 32'h40);

        // PC wraps past the top of the address space
        doReset(1);
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
        #1;
        step();
        PCSrcE = 1'b0;
        #1;
        checkVal("wr_addr", imem_req_addr, 32'hFFFF_FFFC);
        checkVal("wr_req", imem_req_valid, 1);
        step();
        checkVal("wr_addr0", imem_req_addr, 32'h0);
        step();
        checkVal("wr_pcd", PCD, 32'hFFFF_FFFC);
        checkVal("wr_pcp4", PCPlus4D, 32'h0);
        step();
        checkVal("wr_pcd0", PCD, 32'h0);
        checkVal("wr_pcp4b", PCPlus4D, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
